uart_hex_tx: RTL

- Transmit side of the UART text path. Takes a 256-bit SHA-256 digest and sends it as 64 lowercase ASCII hex characters on a UART line, 8N1 format.
- Sits beside the hash core. Its output drives the board TX pin back to the host terminal, the reverse of the path that receives UART bytes into the display text rows.

---
 rtl/uart_hex_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: serialises a digest as lowercase ASCII hex over an 8N1 UART line.
// Optional trailing CR/LF frames are enabled with the macro UART_HEX_TX_CRLF_EN.
module uart_hex_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int NUM_BYTES    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] digest,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             char_index
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int DW = 8 * NUM_BYTES;

`ifdef UART_HEX_TX_CRLF_EN
    localparam logic [6:0] HEX_CHARS = 7'(2 * NUM_BYTES);
    localparam logic [6:0] LAST_CHAR = 7'(2 * NUM_BYTES + 1);
`else
    localparam logic [6:0] LAST_CHAR = 7'(2 * NUM_BYTES - 1);
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   baud_cnt, baud_cnt_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [6:0]      char_n;
    logic [DW-1:0]   shreg, shreg_n;
    logic            tx_n, busy_n, done_n;
    logic [3:0]      nibble;
    logic [7:0]      cur_char;
    logic [2:0]      next_bit;

    // ASCII code of the character currently being framed
    always_comb begin
        nibble   = char_index[0] ? shreg[DW-5 -: 4] : shreg[DW-1 -: 4];
        cur_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
`ifdef UART_HEX_TX_CRLF_EN
        if (char_index == HEX_CHARS)
            cur_char = 8'h0D;
        else if (char_index == HEX_CHARS + 7'd1)
            cur_char = 8'h0A;
`endif
    end

    // Next-state logic; tx/busy/done are computed one cycle ahead so the
    // outputs come straight from flops.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        char_n     = char_index;
        shreg_n    = shreg;
        tx_n       = 1'b1;
        busy_n     = busy;
        done_n     = 1'b0;
        next_bit   = bit_cnt + 3'd1;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    shreg_n    = digest;
                    char_n     = '0;
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = START;
                    busy_n     = 1'b1;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = DATA;
                    tx_n       = cur_char[0];
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                tx_n = cur_char[bit_cnt];
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_cnt_n = next_bit;
                        tx_n      = cur_char[next_bit];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    if (char_index == LAST_CHAR) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        char_n  = '0;
                    end else begin
                        char_n  = char_index + 7'd1;
                        state_n = START;
                        tx_n    = 1'b0;
                        if (char_index[0])
                            shreg_n = shreg << 8;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            char_index <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            char_index <= char_n;
            shreg      <= shreg_n;
            tx         <= tx_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule
